// File: rtl/ray_slab_reducer.sv
// rtl/ray_slab_reducer.sv - folds per-axis slab pairs of one ray into an entry/exit interval and hit flag
// Ordering works directly on the FloPoCo exn/sign/magnitude encoding.
module ray_slab_reducer #(
  parameter int width = 15,
  parameter int NAXES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width:0]   in_t0,
  input  logic [width:0]   in_t1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [width:0]   out_tenter,
  output logic [width:0]   out_texit,
  output logic             out_nan
);

  localparam int CNT_W = (NAXES > 1) ? $clog2(NAXES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NAXES - 1);
  localparam logic [width:0] ZERO = '0;

  typedef enum logic {ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width:0]   tenter_q, tenter_d;
  logic [width:0]   texit_q, texit_d;
  logic             nan_q, nan_d;
  logic             hit_q, hit_d;

  function automatic logic is_nan(input logic [width:0] a);
    return a[width:width-1] == 2'b11;
  endfunction

  // Rank: -inf=0, negative normal=1, zero=2, positive normal=3, +inf=4
  function automatic logic [2:0] rank(input logic [width:0] a);
    logic [2:0] r;
    case (a[width:width-1])
      2'b00:   r = 3'd2;
      2'b01:   r = a[width-2] ? 3'd1 : 3'd3;
      2'b10:   r = a[width-2] ? 3'd0 : 3'd4;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  function automatic logic le(input logic [width:0] a, input logic [width:0] b);
    logic [2:0] ra;
    logic [2:0] rb;
    logic       res;
    ra = rank(a);
    rb = rank(b);
    if (is_nan(a) || is_nan(b))   res = 1'b0;
    else if (ra != rb)            res = ra < rb;
    else if (ra == 3'd1)          res = a[width-3:0] >= b[width-3:0];
    else if (ra == 3'd3)          res = a[width-3:0] <= b[width-3:0];
    else                          res = 1'b1;
    return res;
  endfunction

  logic           pair_le, pair_nan, both_nan;
  logic [width:0] near_v, far_v, enter_new, exit_new;
  logic           nan_new;

  always_comb begin
    both_nan  = is_nan(in_t0) && is_nan(in_t1);
    pair_nan  = is_nan(in_t0) || is_nan(in_t1);
    pair_le   = le(in_t0, in_t1) || both_nan;
    near_v    = pair_le ? in_t0 : in_t1;
    far_v     = pair_le ? in_t1 : in_t0;

    if (cnt_q == '0) begin
      enter_new = near_v;
      exit_new  = far_v;
      nan_new   = pair_nan;
    end else begin
      enter_new = le(tenter_q, near_v) ? near_v : tenter_q;
      exit_new  = le(far_v, texit_q) ? far_v : texit_q;
      nan_new   = nan_q | pair_nan;
    end

    state_d  = state_q;
    cnt_d    = cnt_q;
    tenter_d = tenter_q;
    texit_d  = texit_q;
    nan_d    = nan_q;
    hit_d    = hit_q;

    case (state_q)
      ACC: begin
        if (in_valid) begin
          tenter_d = enter_new;
          texit_d  = exit_new;
          nan_d    = nan_new;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
            hit_d   = !nan_new && le(enter_new, exit_new) && le(ZERO, exit_new);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (out_ready) state_d = ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACC;
      cnt_q    <= '0;
      tenter_q <= '0;
      texit_q  <= '0;
      nan_q    <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tenter_q <= tenter_d;
      texit_q  <= texit_d;
      nan_q    <= nan_d;
      hit_q    <= hit_d;
    end
  end

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == DONE);
  assign out_hit    = hit_q;
  assign out_tenter = tenter_q;
  assign out_texit  = texit_q;
  assign out_nan    = nan_q;

endmodule

// File: tb/tb_ray_slab_reducer.sv
// tb/tb_ray_slab_reducer.sv - directed and random checks of ray_slab_reducer against an ordering-key model
module tb_ray_slab_reducer;

  localparam int NAX = 3;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] in_t0, in_t1;
  logic        in_ready, out_valid, out_hit, out_nan;
  logic [15:0] out_tenter, out_texit;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ray_slab_reducer #(.width(15), .NAXES(NAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_t0(in_t0), .in_t1(in_t1), .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_tenter(out_tenter), .out_texit(out_texit), .out_nan(out_nan)
  );

  // Model state: pairs of the ray in progress and the last finished result
  bit          m_done = 1'b0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] e_te, e_tx;
  bit          e_hit, e_nan;

  function automatic bit isnan(logic [15:0] a);
    return a[15:14] == 2'b11;
  endfunction

  // Signed integer key giving the total order of non-NaN values
  function automatic int key(logic [15:0] a);
    int k;
    case (a[15:14])
      2'b00:   k = 0;
      2'b01:   k = a[13] ? -(int'(a[12:0]) + 1) : (int'(a[12:0]) + 1);
      2'b10:   k = a[13] ? -100000 : 100000;
      default: k = 0;
    endcase
    return k;
  endfunction

  function automatic bit mle(logic [15:0] a, logic [15:0] b);
    return !isnan(a) && !isnan(b) && (key(a) <= key(b));
  endfunction

  function automatic logic [12:0] mag(int m);
    case (m)
      1: return 13'h0F00;
      2: return 13'h1000;
      3: return 13'h1080;
      4: return 13'h1100;
      5: return 13'h1140;
      6: return 13'h1180;
      default: return 13'h0000;
    endcase
  endfunction

  // 100/-100 = +/-inf, 99 = NaN, -99 = -0, otherwise small integer value
  function automatic logic [15:0] enc(int v);
    if (v == 100)  return 16'h8000;
    if (v == -100) return 16'hA000;
    if (v == 99)   return 16'hC000;
    if (v == -99)  return 16'h2000;
    if (v == 0)    return 16'h0000;
    if (v < 0)     return {2'b01, 1'b1, mag(-v)};
    return {2'b01, 1'b0, mag(v)};
  endfunction

  function automatic logic [15:0] rnd_val();
    int kind;
    kind = $urandom_range(0, 19);
    if (kind == 0) return 16'hC000 | 16'($urandom_range(0, 255));
    if (kind == 1) return 16'h8000;
    if (kind == 2) return 16'hA000;
    if (kind <= 4) return {2'b00, 1'($urandom_range(0, 1)), 13'h0};
    return {2'b01, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15) << 8)};
  endfunction

  task automatic finish_ray();
    logic [15:0] nr, fr, te, tx;
    bit nf;
    te = '0; tx = '0; nf = 1'b0;
    for (int i = 0; i < NAX; i++) begin
      if (mle(q0[i], q1[i]) || (isnan(q0[i]) && isnan(q1[i]))) begin
        nr = q0[i]; fr = q1[i];
      end else begin
        nr = q1[i]; fr = q0[i];
      end
      if (i == 0) begin
        te = nr; tx = fr;
      end else begin
        if (mle(te, nr)) te = nr;
        if (mle(fr, tx)) tx = fr;
      end
      nf = nf | isnan(q0[i]) | isnan(q1[i]);
    end
    e_te = te; e_tx = tx; e_nan = nf;
    e_hit = !nf && mle(te, tx) && mle(16'h0000, tx);
    q0.delete(); q1.delete();
    m_done = 1'b1;
  endtask

  task automatic model_tick();
    if (rst) begin
      m_done = 1'b0;
      q0.delete(); q1.delete();
    end else if (!m_done) begin
      if (in_valid) begin
        q0.push_back(in_t0);
        q1.push_back(in_t1);
        if (q0.size() == NAX) finish_ray();
      end
    end else if (out_ready) begin
      m_done = 1'b0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(!m_done));
    chk("out_valid", 32'(out_valid), 32'(m_done));
    if (m_done) begin
      chk("out_tenter", 32'(out_tenter), 32'(e_te));
      chk("out_texit", 32'(out_texit), 32'(e_tx));
      chk("out_hit", 32'(out_hit), 32'(e_hit));
      chk("out_nan", 32'(out_nan), 32'(e_nan));
    end
  endtask

  task automatic step(bit r, bit v, logic [15:0] a, logic [15:0] b, bit ordy);
    rst = r; in_valid = v; in_t0 = a; in_t1 = b; out_ready = ordy;
    model_tick();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run_ray(string name, int a0, int b0, int a1, int b1, int a2, int b2,
                         int te, int tx, bit hit, bit nan_exp, bit chk_vals);
    step(0, 1, enc(a0), enc(b0), 1);
    step(0, 1, enc(a1), enc(b1), 1);
    step(0, 1, enc(a2), enc(b2), 1);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_hit"}, 32'(out_hit), 32'(hit));
    chk({name, "_nan"}, 32'(out_nan), 32'(nan_exp));
    if (chk_vals) begin
      chk({name, "_tenter"}, 32'(out_tenter), 32'(enc(te)));
      chk({name, "_texit"}, 32'(out_texit), 32'(enc(tx)));
    end
    step(0, 0, 16'h0, 16'h0, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_t0 = '0; in_t1 = '0; out_ready = 1'b0;
    step(1, 0, 16'h0, 16'h0, 0);
    step(1, 0, 16'h0, 16'h0, 0);
    step(0, 0, 16'h0, 16'h0, 0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_hit", 32'(out_hit), 32'd0);
    chk("rst_out_nan", 32'(out_nan), 32'd0);
    chk("rst_tenter", 32'(out_tenter), 32'd0);
    chk("rst_texit", 32'(out_texit), 32'd0);

    run_ray("basic", 1, 4, 2, 5, 0, 3, 2, 3, 1, 0, 1);
    run_ray("swapped", 4, 1, 5, 2, 3, 0, 2, 3, 1, 0, 1);
    run_ray("miss", 1, 2, 3, 4, 0, 5, 3, 2, 0, 0, 1);
    run_ray("behind", -5, -1, -4, -2, -6, -3, -4, -3, 0, 0, 1);
    run_ray("touch", 1, 2, 2, 5, 0, 3, 2, 2, 1, 0, 1);
    run_ray("negzero", -1, -99, -2, 0, -3, -99, -1, -99, 1, 0, 1);
    run_ray("infpair", 1, 4, -100, 100, 2, 3, 2, 3, 1, 0, 1);
    run_ray("nan", 1, 4, 99, 5, 0, 3, 0, 0, 0, 1, 0);
    run_ray("clean", 1, 4, 2, 5, 0, 3, 2, 3, 1, 0, 1);
    run_ray("plusinf_near", 100, 100, 1, 4, 2, 3, 0, 0, 0, 0, 0);

    // Backpressure: result held while extra pairs are offered and ignored
    step(0, 1, enc(1), enc(4), 0);
    step(0, 1, enc(2), enc(5), 0);
    step(0, 1, enc(0), enc(3), 0);
    for (int i = 0; i < 5; i++) step(0, 1, rnd_val(), rnd_val(), 0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_texit", 32'(out_texit), 32'(enc(3)));
    step(0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 16'h0, 1);

    // Reset mid-ray discards the first two axes
    step(0, 1, enc(6), enc(6), 1);
    step(0, 1, enc(-6), enc(-6), 1);
    step(1, 0, 16'h0, 16'h0, 1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_tenter", 32'(out_tenter), 32'd0);
    run_ray("after_rst", 1, 2, 2, 5, 0, 3, 2, 2, 1, 0, 1);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           rnd_val(), rnd_val(), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
